// File: rtl/cascade_sched_pkg.sv
// cascade_sched_pkg
// Shared definitions for the cascade stage sequencer: the FSM state encoding,
// default configuration constants, the stage-index width helper and the
// packed layouts of the stage request and detection result words.
// No ports (package).

package cascade_sched_pkg;

  // Sequencer states: wait for a window, issue a stage request, wait for the
  // stage verdict, then hand the detection result downstream.
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    REPORT
  } state_e;

  localparam int STAGE_NUM_DEF = 25;
  localparam int W_ADDR_DEF    = 16;

  // Width of a stage index. A single-stage cascade still gets one bit so that
  // the index field never collapses to zero width.
  function automatic int stage_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int W_STAGE_DEF = stage_width(STAGE_NUM_DEF);

  // Request to the shared stage evaluator. eot marks the final stage.
  typedef struct packed {
    logic                   eot;
    logic [W_ADDR_DEF-1:0]  addr;
    logic [W_STAGE_DEF-1:0] stage;
  } stage_req_t;

  // Per-window detection result. depth is the last stage that was evaluated.
  typedef struct packed {
    logic [W_ADDR_DEF-1:0]  addr;
    logic                   detected;
    logic [W_STAGE_DEF-1:0] depth;
  } dout_t;

endpackage

// File: rtl/cascade_stage_sched_if.sv
// dti
// Generic valid/ready data-transfer interface used on every stream port of
// the cascade stage sequencer.
//   valid : producer -> consumer, data is meaningful
//   ready : consumer -> producer, consumer accepts this cycle
//   data  : producer -> consumer, W bits of payload
// A transfer happens on a clock edge where both valid and ready are high.

interface dti #(
  parameter int W = 1
) ();

  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer (
    output valid,
    output data,
    input  ready
  );

  modport consumer (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/cascade_stage_sched.sv
// cascade_stage_sched
// Per-window stage sequencer for the cascade classifier. Accepts one window
// address, walks the stage evaluator through stages 0..STAGE_NUM-1 one
// request at a time, stops at the first reject and emits one detection
// result per window.
// Ports:
//   clk       : clock
//   rst       : synchronous active-high reset
//   win       : consumer, window address (W_ADDR bits)
//   stage_req : producer, {eot, addr, stage} to the stage evaluator
//   stage_res : consumer, 1 = stage passed, 0 = rejected
//   dout      : producer, {addr, detected, depth}

module cascade_stage_sched
  import cascade_sched_pkg::*;
#(
  parameter  int STAGE_NUM = 25,
  parameter  int W_ADDR    = 16,
  localparam int W_STAGE   = stage_width(STAGE_NUM)
) (
  input  logic  clk,
  input  logic  rst,
  dti.consumer  win,
  dti.producer  stage_req,
  dti.consumer  stage_res,
  dti.producer  dout
);

  localparam logic [W_STAGE-1:0] LAST_STAGE = W_STAGE'(STAGE_NUM - 1);

  typedef struct packed {
    logic               eot;
    logic [W_ADDR-1:0]  addr;
    logic [W_STAGE-1:0] stage;
  } req_word_t;

  typedef struct packed {
    logic [W_ADDR-1:0]  addr;
    logic               detected;
    logic [W_STAGE-1:0] depth;
  } dout_word_t;

  state_e             state_q, state_d;
  logic [W_ADDR-1:0]  addr_q, addr_d;
  logic [W_STAGE-1:0] stage_q, stage_d;
  logic               det_q, det_d;

  logic               last_stage;

  assign last_stage = (stage_q == LAST_STAGE);

  // State and datapath registers; reset drops any window in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      stage_q <= '0;
      det_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      stage_q <= stage_d;
      det_q   <= det_d;
    end
  end

  // Next-state logic. The stage counter only advances on a pass that is not
  // the final stage, so it never exceeds STAGE_NUM-1.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    stage_d = stage_q;
    det_d   = det_q;
    unique case (state_q)
      IDLE: begin
        if (win.valid) begin
          addr_d  = win.data;
          stage_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (stage_req.ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (stage_res.valid) begin
          if (!stage_res.data[0]) begin
            det_d   = 1'b0;
            state_d = REPORT;
          end else if (last_stage) begin
            det_d   = 1'b1;
            state_d = REPORT;
          end else begin
            stage_d = stage_q + W_STAGE'(1);
            state_d = ISSUE;
          end
        end
      end
      REPORT: begin
        if (dout.ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Window input: only accept a new address while no window is in flight.
  always_comb begin
    win.ready = (state_q == IDLE);
  end

  // Stage request: the payload is taken straight from registers, so it stays
  // stable for as long as the evaluator holds off ready.
  always_comb begin
    req_word_t req;
    req.eot         = last_stage;
    req.addr        = addr_q;
    req.stage       = stage_q;
    stage_req.valid = (state_q == ISSUE);
    stage_req.data  = req;
  end

  // Stage result: a verdict that arrives early simply waits until WAIT.
  always_comb begin
    stage_res.ready = (state_q == WAIT);
  end

  // Detection result.
  always_comb begin
    dout_word_t res;
    res.addr     = addr_q;
    res.detected = det_q;
    res.depth    = stage_q;
    dout.valid   = (state_q == REPORT);
    dout.data    = res;
  end

endmodule

// File: tb/tb_cascade_stage_sched.sv
// tb_cascade_stage_sched
// Directed testbench for cascade_stage_sched. Instance A runs a 4-stage
// cascade, instance B a single-stage cascade; both share clock and reset.
// No ports (top-level bench).

module tb_cascade_stage_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  dti #(.W(16)) winA ();
  dti #(.W(19)) reqA ();
  dti #(.W(1))  resA ();
  dti #(.W(19)) doutA ();

  dti #(.W(16)) winB ();
  dti #(.W(18)) reqB ();
  dti #(.W(1))  resB ();
  dti #(.W(18)) doutB ();

  cascade_stage_sched #(.STAGE_NUM(4), .W_ADDR(16)) dutA (
    .clk       (clk),
    .rst       (rst),
    .win       (winA),
    .stage_req (reqA),
    .stage_res (resA),
    .dout      (doutA)
  );

  cascade_stage_sched #(.STAGE_NUM(1), .W_ADDR(16)) dutB (
    .clk       (clk),
    .rst       (rst),
    .win       (winB),
    .stage_req (reqB),
    .stage_res (resB),
    .dout      (doutB)
  );

  always #5 clk = ~clk;

  // Handshake monitors for instance A: log every stage request and count
  // result and output transfers.
  int         reqCountA  = 0;
  int         resCountA  = 0;
  int         doutCountA = 0;
  int         reqCountB  = 0;
  logic [1:0] stageLogA [32];
  logic       eotLogA [32];
  logic [1:0] lastStageA = 2'd0;
  int         rejectAtA  = 7;

  always @(posedge clk) begin
    if (reqA.valid && reqA.ready) begin
      reqCountA                <= reqCountA + 1;
      stageLogA[reqCountA % 32] <= reqA.data[1:0];
      eotLogA[reqCountA % 32]   <= reqA.data[18];
      lastStageA               <= reqA.data[1:0];
    end
    if (resA.valid && resA.ready) resCountA <= resCountA + 1;
    if (doutA.valid && doutA.ready) doutCountA <= doutCountA + 1;
    if (reqB.valid && reqB.ready) reqCountB <= reqCountB + 1;
  end

  // Stage evaluator stand-in for A: passes every stage except rejectAtA.
  assign resA.data = (int'(lastStageA) != rejectAtA);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one window to instance A for a single accepting edge.
  task automatic applyStimulus(input logic [15:0] addr);
    winA.valid = 1'b1;
    winA.data  = addr;
    tick();
    winA.valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int resBase;
    int doutBase;

    winA.valid = 1'b0; winA.data = '0;
    reqA.ready = 1'b1;
    resA.valid = 1'b1;
    doutA.ready = 1'b0;
    winB.valid = 1'b0; winB.data = '0;
    reqB.ready = 1'b1;
    resB.valid = 1'b1; resB.data = 1'b1;
    doutB.ready = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    checkOutput("rst_win_ready", winA.ready, 1);
    checkOutput("rst_req_valid", reqA.valid, 0);
    checkOutput("rst_res_ready", resA.ready, 0);
    checkOutput("rst_dout_valid", doutA.valid, 0);

    // All four stages pass
    $display("[TB] all-pass window");
    rejectAtA = 7;
    base = reqCountA;
    resBase = resCountA;
    doutBase = doutCountA;
    applyStimulus(16'h0012);
    checkOutput("pass_req_valid_c1", reqA.valid, 1);
    checkOutput("pass_req_data_c1", reqA.data, {1'b0, 16'h0012, 2'd0});
    checkOutput("pass_win_ready_c1", winA.ready, 0);
    repeat (7) tick();
    checkOutput("pass_dout_valid_c8", doutA.valid, 0);
    tick();
    checkOutput("pass_dout_valid_c9", doutA.valid, 1);
    checkOutput("pass_dout_data", doutA.data, {16'h0012, 1'b1, 2'd3});
    checkOutput("pass_req_count", reqCountA - base, 4);
    checkOutput("pass_res_count", resCountA - resBase, 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("pass_stage_seq", stageLogA[(base + i) % 32], i);
      checkOutput("pass_eot_seq", eotLogA[(base + i) % 32], (i == 3) ? 1 : 0);
    end
    doutA.ready = 1'b1;
    tick();
    doutA.ready = 1'b0;
    checkOutput("pass_dout_done", doutA.valid, 0);
    checkOutput("pass_win_ready_back", winA.ready, 1);
    checkOutput("pass_dout_count", doutCountA - doutBase, 1);

    // Reject on stage 1
    $display("[TB] reject at stage 1");
    rejectAtA = 1;
    base = reqCountA;
    applyStimulus(16'h00A5);
    repeat (4) tick();
    checkOutput("rej1_dout_valid", doutA.valid, 1);
    checkOutput("rej1_dout_data", doutA.data, {16'h00A5, 1'b0, 2'd1});
    repeat (2) tick();
    checkOutput("rej1_dout_hold", doutA.valid, 1);
    checkOutput("rej1_req_count", reqCountA - base, 2);
    doutA.ready = 1'b1;
    tick();
    doutA.ready = 1'b0;

    // Backpressure on stage_req and dout
    $display("[TB] backpressure");
    rejectAtA = 7;
    base = reqCountA;
    resBase = resCountA;
    reqA.ready = 1'b0;
    applyStimulus(16'h0BEE);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_req_valid", reqA.valid, 1);
      checkOutput("bp_req_data", reqA.data, {1'b0, 16'h0BEE, 2'd0});
      checkOutput("bp_win_ready", winA.ready, 0);
      checkOutput("bp_res_ready", resA.ready, 0);
      tick();
    end
    reqA.ready = 1'b1;
    for (int i = 0; i < 20 && !doutA.valid; i++) tick();
    checkOutput("bp_dout_timeout", doutA.valid, 1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_dout_valid", doutA.valid, 1);
      checkOutput("bp_dout_data", doutA.data, {16'h0BEE, 1'b1, 2'd3});
      checkOutput("bp_dout_win_ready", winA.ready, 0);
      tick();
    end
    checkOutput("bp_req_count", reqCountA - base, 4);
    checkOutput("bp_res_count", resCountA - resBase, 4);
    doutA.ready = 1'b1;
    tick();
    doutA.ready = 1'b0;
    checkOutput("bp_dout_done", doutA.valid, 0);

    // Stage result presented early, during a stalled ISSUE
    $display("[TB] early stage result");
    rejectAtA = 0;
    resBase = resCountA;
    reqA.ready = 1'b0;
    resA.valid = 1'b1;
    applyStimulus(16'h0C0D);
    for (int i = 0; i < 3; i++) begin
      checkOutput("early_res_ready", resA.ready, 0);
      tick();
    end
    checkOutput("early_res_unconsumed", resCountA - resBase, 0);
    reqA.ready = 1'b1;
    repeat (2) tick();
    checkOutput("early_dout_valid", doutA.valid, 1);
    checkOutput("early_dout_data", doutA.data, {16'h0C0D, 1'b0, 2'd0});
    checkOutput("early_res_count", resCountA - resBase, 1);
    doutA.ready = 1'b1;
    tick();
    doutA.ready = 1'b0;

    // Single-stage cascade
    $display("[TB] single-stage cascade");
    base = reqCountB;
    resB.data = 1'b1;
    winB.valid = 1'b1;
    winB.data = 16'h0033;
    tick();
    winB.valid = 1'b0;
    checkOutput("one_req_valid", reqB.valid, 1);
    checkOutput("one_req_data", reqB.data, {1'b1, 16'h0033, 1'b0});
    repeat (2) tick();
    checkOutput("one_dout_valid", doutB.valid, 1);
    checkOutput("one_dout_pass", doutB.data, {16'h0033, 1'b1, 1'b0});
    checkOutput("one_req_count", reqCountB - base, 1);
    doutB.ready = 1'b1;
    tick();
    resB.data = 1'b0;
    winB.valid = 1'b1;
    winB.data = 16'h0044;
    tick();
    winB.valid = 1'b0;
    repeat (2) tick();
    checkOutput("one_dout_reject", doutB.data, {16'h0044, 1'b0, 1'b0});
    tick();
    doutB.ready = 1'b0;

    // Reset during WAIT of stage 2
    $display("[TB] reset mid-window");
    rejectAtA = 7;
    doutA.ready = 1'b1;
    applyStimulus(16'h0055);
    repeat (5) tick();
    checkOutput("rstw_in_wait", resA.ready, 1);
    checkOutput("rstw_stage", lastStageA, 2);
    doutBase = doutCountA;
    rst = 1'b1;
    tick();
    checkOutput("rstw_req_valid", reqA.valid, 0);
    checkOutput("rstw_res_ready", resA.ready, 0);
    checkOutput("rstw_dout_valid", doutA.valid, 0);
    checkOutput("rstw_win_ready", winA.ready, 1);
    rst = 1'b0;
    repeat (3) tick();
    checkOutput("rstw_no_dout", doutCountA - doutBase, 0);
    rejectAtA = 0;
    base = reqCountA;
    applyStimulus(16'h0077);
    checkOutput("rstw_new_req", reqA.data, {1'b0, 16'h0077, 2'd0});
    repeat (2) tick();
    checkOutput("rstw_new_dout_valid", doutA.valid, 1);
    checkOutput("rstw_new_dout_data", doutA.data, {16'h0077, 1'b0, 2'd0});
    checkOutput("rstw_new_stage0", stageLogA[base % 32], 0);
    tick();
    doutA.ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cascade_stage_sched.md
# cascade_stage_sched

Per-window stage sequencer for the cascade classifier. It accepts one window address at a time and issues stage-evaluation requests to the shared stage evaluator in order 0..STAGE_NUM-1. It consumes the per-stage pass bit and stops early on the first reject. It emits one detection result per window, so the evaluator sees exactly the stage stream that a yield-on-reject/eot consumer expects.

## Interface
Parameters:
- STAGE_NUM, 25, number of cascade stages; minimum 1.
- W_ADDR, 16, window address width.
- W_STAGE, max(1, $clog2(STAGE_NUM)), stage index width (derived).

Ports:
- clk  input  1  clock; the only clock domain.
- rst  input  1  synchronous, active-high reset.
- win  dti.consumer  W_ADDR  window address to classify.
- stage_req  dti.producer  1+W_ADDR+W_STAGE  packed {eot, addr, stage}; eot=1 on stage STAGE_NUM-1.
- stage_res  dti.consumer  1  stage result: 1 = pass, 0 = reject.
- dout  dti.producer  W_ADDR+1+W_STAGE  packed {addr, detected, depth}; depth = index of the last stage evaluated.

## Operation
- FSM states: IDLE, ISSUE, WAIT, REPORT. Registers: state, addr_r, stage_r, det_r.
- IDLE:
  - win.ready=1.
  - On win.valid: addr_r<=win.data, stage_r<=0, go to ISSUE.
- ISSUE:
  - stage_req.valid=1, data={stage_r==STAGE_NUM-1, addr_r, stage_r}.
  - On stage_req.ready: go to WAIT.
- WAIT:
  - stage_res.ready=1.
  - On stage_res.valid with data 0: det_r<=0, go to REPORT.
  - On data 1 and stage_r==STAGE_NUM-1: det_r<=1, go to REPORT.
  - On data 1 otherwise: stage_r<=stage_r+1, go to ISSUE.
- REPORT:
  - dout.valid=1, data={addr_r, det_r, stage_r}.
  - On dout.ready: go to IDLE.
- Handshake rules:
  - All valid/ready outputs are decoded from state only. There is no combinational path from any input ready/valid to an output valid/ready.
  - Only one stage request is outstanding at any time.
  - stage_res arriving outside WAIT is not consumed (ready=0) and stays pending until WAIT.
  - win.ready is 0 outside IDLE, so no new window is accepted until dout completes.
- Arithmetic: stage_r never exceeds STAGE_NUM-1, so there is no wrap. With STAGE_NUM=1, every request carries eot=1 and the first result terminates.
- A stage_res value of 1 on the final stage together with eot produces detected=1. A 0 on any stage produces detected=0 with depth equal to that stage.

## Timing
- Reset values:
  - state=IDLE.
  - addr_r=0, stage_r=0, det_r=0.
  - win.ready=1 in the cycle after reset deasserts.
  - stage_req.valid=0, stage_res.ready=0, dout.valid=0.
- Reset mid-operation: the FSM returns to IDLE and the current window is dropped with no dout. The stage evaluator shares rst, so no stale result remains pending.
- Latency, with all counterparts ready immediately:
  - Window accept at cycle 0.
  - First stage_req.valid at cycle 1.
  - Each stage costs 2 cycles (ISSUE, WAIT) when its result returns in the WAIT cycle.
  - dout.valid at cycle 1+2k for a window ending at stage k-1.
  - Example: reject at stage 0 gives dout.valid at cycle 3.
- Backpressure: stage_req and dout hold their data and valid stable until ready.
- Throughput: one window per 2k+2 cycles minimum.

## Structure
- Shared package cascade_sched_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, REPORT);
  - the stage_req_t and dout_t packed structs, parameterised via localparams derived from STAGE_NUM and W_ADDR.
- No sub-module: the stage counter and FSM are inline, as one sequential block plus one comb block per output interface.

## Test plan
- STAGE_NUM=4, win=0x0012, all results 1:
  - 4 requests with stage 0..3, eot only on stage 3.
  - dout={0x0012, 1, 3} at cycle 9.
- Result 0 on stage 1:
  - exactly 2 requests issued.
  - dout={addr, 0, 1}; no stage 2 request.
- Backpressure:
  - hold stage_req.ready=0 for 5 cycles and dout.ready=0 for 3 cycles.
  - data and valid stay stable, no duplicate requests, win.ready stays 0 throughout.
- stage_res.valid asserted early, during ISSUE: it is not consumed until WAIT, and is counted once.
- STAGE_NUM=1: a single request with eot=1; result 1 gives detected=1 and depth 0.
- rst pulsed during WAIT of stage 2:
  - next cycle all valids are 0 and win.ready=1.
  - a new window then runs from stage 0.
